// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants, sync polarity and the
// 10-bit count type used by the sync generator and the downstream
// sync-to-count / drawing logic.
package vga_timing_pkg;

   // Width of every column/row counter in the video path.
   localparam int COUNT_W = 10;

   // Largest raster either counter can describe.
   localparam int COUNT_MAX = 1 << COUNT_W;

   typedef logic [COUNT_W-1:0] count_t;

   // 640x480@60 Hz defaults (25.175 MHz pixel clock).
   localparam int DEF_TOTAL_COLS    = 800;
   localparam int DEF_TOTAL_ROWS    = 525;
   localparam int DEF_ACTIVE_COLS   = 640;
   localparam int DEF_ACTIVE_ROWS   = 480;
   localparam int DEF_H_FRONT_PORCH = 16;
   localparam int DEF_H_SYNC_WIDTH  = 96;
   localparam int DEF_V_FRONT_PORCH = 10;
   localparam int DEF_V_SYNC_WIDTH  = 2;
   localparam int DEF_SYNC_DELAY    = 2;

   // Both HSync and VSync are active-low in this mode.
   localparam logic SYNC_ACTIVE_LEVEL = 1'b0;

   // Inclusive window test used for the sync pulse decodes.
   function automatic logic in_window(input count_t value,
                                      input count_t lo,
                                      input count_t hi);
      return (value >= lo) && (value <= hi);
   endfunction

   // Sync level for a position: active level inside the pulse window.
   function automatic logic sync_level(input logic in_pulse);
      return in_pulse ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: enable-gated delay line whose stages reset to all-ones
// (the idle level of active-low syncs). DEPTH=0 degenerates to a wire.
module vga_sync_delay #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic             i_Clk,
   input  logic             i_Reset,
   input  logic             i_Enable,
   input  logic [WIDTH-1:0] i_Data,
   output logic [WIDTH-1:0] o_Data
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign o_Data = i_Data;
      end else begin : g_line
         for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] w_stage_in;
            logic [WIDTH-1:0] r_q;

            if (gi == 0) begin : g_first
               assign w_stage_in = i_Data;
            end else begin : g_chain
               assign w_stage_in = g_stage[gi-1].r_q;
            end

            // One stage: loads idle-high on reset, shifts only on pixel enable.
            always_ff @(posedge i_Clk) begin
               if (i_Reset) begin
                  r_q <= '1;
               end else if (i_Enable) begin
                  r_q <= w_stage_in;
               end
            end
         end

         assign o_Data = g_stage[DEPTH-1].r_q;
      end
   endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing source. Column/row counters with registered
// HSync/VSync/active/frame-start decodes taken from the next-state counts, so
// every output in a cycle describes the same pixel.
// Optional build macro VGA_SYNC_ALIGN_EN: routes HSync/VSync through a
// SYNC_DELAY-stage enable-gated delay line to line them up with the
// downstream count/draw pipeline; counts, active and frame start are not delayed.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
   parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
   parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
   parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
   parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
   parameter int H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
   parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
   parameter int V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH,
   parameter int SYNC_DELAY    = DEF_SYNC_DELAY
) (
   input  logic               i_Clk,
   input  logic               i_Reset,
   input  logic               i_Enable,
   output logic               o_HSync,
   output logic               o_VSync,
   output logic [COUNT_W-1:0] o_Col_Count,
   output logic [COUNT_W-1:0] o_Row_Count,
   output logic               o_Active,
   output logic               o_Frame_Start
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ------------------------------------------------------------------
   generate
      if (TOTAL_COLS > COUNT_MAX || TOTAL_ROWS > COUNT_MAX ||
          TOTAL_COLS < 1 || TOTAL_ROWS < 1) begin : g_bad_totals
         $error("vga_sync_gen: TOTAL_COLS/TOTAL_ROWS must be in 1..1024");
      end
      if (ACTIVE_COLS > TOTAL_COLS || ACTIVE_ROWS > TOTAL_ROWS) begin : g_bad_active
         $error("vga_sync_gen: active area larger than total raster");
      end
      if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS ||
          ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS ||
          H_SYNC_WIDTH < 1 || V_SYNC_WIDTH < 1) begin : g_bad_sync
         $error("vga_sync_gen: sync pulse does not fit inside the blanking interval");
      end
      if (SYNC_DELAY < 0) begin : g_bad_delay
         $error("vga_sync_gen: SYNC_DELAY must be non-negative");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Derived constants, all in counter width
   // ------------------------------------------------------------------
   localparam count_t L_COL_LAST = count_t'(TOTAL_COLS - 1);
   localparam count_t L_ROW_LAST = count_t'(TOTAL_ROWS - 1);
   localparam count_t L_HS_FIRST = count_t'(ACTIVE_COLS + H_FRONT_PORCH);
   localparam count_t L_HS_LAST  = count_t'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
   localparam count_t L_VS_FIRST = count_t'(ACTIVE_ROWS + V_FRONT_PORCH);
   localparam count_t L_VS_LAST  = count_t'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
   // One bit wider so an active area of exactly 1024 still compares correctly.
   localparam logic [COUNT_W:0] L_ACT_COLS = ACTIVE_COLS[COUNT_W:0];
   localparam logic [COUNT_W:0] L_ACT_ROWS = ACTIVE_ROWS[COUNT_W:0];

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   count_t r_col;
   count_t r_row;
   logic   r_hsync;
   logic   r_vsync;
   logic   r_active;
   logic   r_frame_start;
   // Set by reset: the first enabled cycle afterwards presents (0,0) with a
   // frame-start strobe instead of advancing past it.
   logic   r_start_pending;

   count_t w_col_next;
   count_t w_row_next;
   logic   w_advance;
   logic   w_frame_wrap;
   logic   w_hsync_next;
   logic   w_vsync_next;
   logic   w_active_next;
   logic   w_frame_start_next;

   // Next-state raster position and the decodes of that position.
   always_comb begin
      w_col_next   = r_col;
      w_row_next   = r_row;
      w_frame_wrap = 1'b0;
      w_advance    = i_Enable & ~r_start_pending;

      if (w_advance) begin
         if (r_col == L_COL_LAST) begin
            w_col_next = '0;
            if (r_row == L_ROW_LAST) begin
               w_row_next   = '0;
               w_frame_wrap = 1'b1;
            end else begin
               w_row_next = r_row + count_t'(1);
            end
         end else begin
            w_col_next = r_col + count_t'(1);
         end
      end

      w_hsync_next  = sync_level(in_window(w_col_next, L_HS_FIRST, L_HS_LAST));
      w_vsync_next  = sync_level(in_window(w_row_next, L_VS_FIRST, L_VS_LAST));
      w_active_next = ({1'b0, w_col_next} < L_ACT_COLS) &&
                      ({1'b0, w_row_next} < L_ACT_ROWS);
      // Strobe only on an enabled cycle that lands on (0,0) afresh.
      w_frame_start_next = i_Enable & (r_start_pending | w_frame_wrap);
   end

   // Counter and registered decode update; everything holds while disabled.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_col           <= '0;
         r_row           <= '0;
         r_hsync         <= ~SYNC_ACTIVE_LEVEL;
         r_vsync         <= ~SYNC_ACTIVE_LEVEL;
         r_active        <= 1'b0;
         r_frame_start   <= 1'b0;
         r_start_pending <= 1'b1;
      end else begin
         r_frame_start <= w_frame_start_next;
         if (i_Enable) begin
            r_col           <= w_col_next;
            r_row           <= w_row_next;
            r_hsync         <= w_hsync_next;
            r_vsync         <= w_vsync_next;
            r_active        <= w_active_next;
            r_start_pending <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign o_Col_Count   = r_col;
   assign o_Row_Count   = r_row;
   assign o_Active      = r_active;
   assign o_Frame_Start = r_frame_start;

`ifdef VGA_SYNC_ALIGN_EN
   logic [1:0] w_sync_delayed;

   vga_sync_delay #(
      .WIDTH (2),
      .DEPTH (SYNC_DELAY)
   ) u_sync_delay (
      .i_Clk    (i_Clk),
      .i_Reset  (i_Reset),
      .i_Enable (i_Enable),
      .i_Data   ({r_hsync, r_vsync}),
      .o_Data   (w_sync_delayed)
   );

   assign o_HSync = w_sync_delayed[1];
   assign o_VSync = w_sync_delayed[0];
`else
   assign o_HSync = r_hsync;
   assign o_VSync = r_vsync;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: self-checking bench for vga_sync_gen. Full-width lines
// (800 columns, default horizontal timing) with a shortened 20-line frame so
// whole-frame behaviour is exercised quickly. Every cycle is compared against a
// behavioural raster model through a scoreboard queue; table vectors and
// hand-written sequences add literal expectations for the corner cases.
module tb_vga_sync_gen;
   import vga_timing_pkg::*;

   localparam int T_COLS = 800;
   localparam int A_COLS = 640;
   localparam int HFP    = 16;
   localparam int HSW    = 96;
   localparam int T_ROWS = 20;
   localparam int A_ROWS = 12;
   localparam int VFP    = 3;
   localparam int VSW    = 2;
   localparam int SDLY   = 2;
`ifdef VGA_SYNC_ALIGN_EN
   localparam int DLY = SDLY;
`else
   localparam int DLY = 0;
`endif
   localparam int HS_LO = A_COLS + HFP;
   localparam int HS_HI = A_COLS + HFP + HSW - 1;
   localparam int VS_LO = A_ROWS + VFP;
   localparam int VS_HI = A_ROWS + VFP + VSW - 1;

   typedef struct packed {
      logic [9:0] col;
      logic [9:0] row;
      logic       hs;
      logic       vs;
      logic       act;
      logic       fs;
   } obs_t;

   typedef struct {
      logic rst;
      logic en;
      obs_t exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic       hs, vs, act, fs;
   logic [9:0] col, row;

   int n_checks = 0;
   int n_errors = 0;
   obs_t sb_q[$];

   // Behavioural model state
   int         m_col, m_row;
   bit         m_pend;
   logic [1:0] m_raw;
   logic [1:0] m_hist[8];
   logic       m_act, m_fs;

   vga_sync_gen #(
      .TOTAL_COLS(T_COLS), .TOTAL_ROWS(T_ROWS),
      .ACTIVE_COLS(A_COLS), .ACTIVE_ROWS(A_ROWS),
      .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW),
      .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW),
      .SYNC_DELAY(SDLY)
   ) dut (
      .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
      .o_HSync(hs), .o_VSync(vs),
      .o_Col_Count(col), .o_Row_Count(row),
      .o_Active(act), .o_Frame_Start(fs)
   );

   always #5 clk = ~clk;

   // Advance the raster model by one clock with the given inputs.
   function automatic obs_t model_step(input logic r, input logic e);
      logic [1:0] old_raw;
      obs_t       o;
      int         idx;
      if (r) begin
         m_col = 0; m_row = 0; m_pend = 1'b1; m_raw = 2'b11;
         for (int k = 0; k < 8; k++) m_hist[k] = 2'b11;
         m_act = 1'b0; m_fs = 1'b0;
      end else if (e) begin
         old_raw = m_raw;
         if (m_pend) begin
            m_pend = 1'b0;
            m_fs   = 1'b1;
         end else begin
            m_fs = 1'b0;
            if (m_col == T_COLS - 1) begin
               m_col = 0;
               if (m_row == T_ROWS - 1) begin
                  m_row = 0;
                  m_fs  = 1'b1;
               end else begin
                  m_row++;
               end
            end else begin
               m_col++;
            end
         end
         m_raw[1] = !(m_col >= HS_LO && m_col <= HS_HI);
         m_raw[0] = !(m_row >= VS_LO && m_row <= VS_HI);
         m_act    = (m_col < A_COLS) && (m_row < A_ROWS);
         for (int k = 7; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = old_raw;
      end else begin
         m_fs = 1'b0;
      end
      idx   = DLY - 1;
      o.col = 10'(m_col);
      o.row = 10'(m_row);
      if (idx < 0) {o.hs, o.vs} = m_raw;
      else         {o.hs, o.vs} = m_hist[idx];
      o.act = m_act;
      o.fs  = m_fs;
      return o;
   endfunction

   task automatic check_int(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Drive one cycle; expectation pushed at drive time, popped after the edge.
   task automatic sb_step(input logic r, input logic e, input bit use_tbl, input obs_t tbl_exp);
      obs_t mexp, want, got;
      mexp = model_step(r, e);
      rst = r;
      en  = e;
      sb_q.push_back(use_tbl ? tbl_exp : mexp);
      @(posedge clk);
      #1;
      got  = {col, row, hs, vs, act, fs};
      want = sb_q.pop_front();
      n_checks++;
      if (got !== want) begin
         n_errors++;
         if (n_errors <= 20)
            $display("FAIL scoreboard: got col=%0d row=%0d hs=%b vs=%b act=%b fs=%b, expected col=%0d row=%0d hs=%b vs=%b act=%b fs=%b",
                     got.col, got.row, got.hs, got.vs, got.act, got.fs,
                     want.col, want.row, want.hs, want.vs, want.act, want.fs);
      end
   endtask

   task automatic run_to(input int c, input int r, input int bound);
      bit hit = 0;
      for (int k = 0; k < bound; k++) begin
         if (m_col == c && m_row == r) begin
            hit = 1;
            break;
         end
         sb_step(1'b0, 1'b1, 1'b0, '0);
      end
      check_int($sformatf("reach_%0d_%0d", c, r), int'(hit), 1);
   endtask

   // Run the rest of the current line, measuring HSync and active spans.
   task automatic line_check(input string name, input int exp_active);
      int hs_low = 0, act_n = 0, first = -1, r0;
      bit done = 0;
      r0 = int'(row);
      if (!hs) begin hs_low++; first = int'(col); end
      if (act) act_n++;
      for (int k = 0; k < 2 * T_COLS; k++) begin
         sb_step(1'b0, 1'b1, 1'b0, '0);
         if (int'(row) != r0) begin done = 1; break; end
         if (!hs) begin
            if (first < 0) first = int'(col);
            hs_low++;
         end
         if (act) act_n++;
      end
      check_int({name, "_row_advanced"}, int'(done), 1);
      check_int({name, "_hs_low_cycles"}, hs_low, HSW);
      check_int({name, "_hs_first_col"}, first, HS_LO + DLY);
      check_int({name, "_active_cycles"}, act_n, exp_active);
      check_int({name, "_wrap_col"}, int'(col), 0);
      check_int({name, "_wrap_row"}, int'(row), r0 + 1);
      $display("line %s: hs_low=%0d first=%0d active=%0d", name, hs_low, first, act_n);
   endtask

   task automatic hand_step(input string name, input logic e, input int exp_col,
                            input int exp_row, input logic exp_hs, input logic exp_fs);
      sb_step(1'b0, e, 1'b0, '0);
      check_int({name, "_col"}, int'(col), exp_col);
      check_int({name, "_row"}, int'(row), exp_row);
      check_int({name, "_hs"}, int'(hs), int'(exp_hs));
      check_int({name, "_fs"}, int'(fs), int'(exp_fs));
      $display("step %s: en=%b col=%0d row=%0d hs=%b fs=%b", name, e, col, row, hs, fs);
   endtask

   initial begin
      vec_t tbl[10];
      int   period, vs_low, act_n, late_act, pc, pr;
      bit   found;

      // Reset for 5 cycles, release, then gated counting from (0,0).
      for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b1, '{10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[5] = '{1'b0, 1'b1, '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1}};
      tbl[6] = '{1'b0, 1'b1, '{10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};
      tbl[7] = '{1'b0, 1'b0, '{10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};
      tbl[8] = '{1'b0, 1'b1, '{10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};
      tbl[9] = '{1'b0, 1'b1, '{10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}};

      for (int i = 0; i < 10; i++) begin
         sb_step(tbl[i].rst, tbl[i].en, 1'b1, tbl[i].exp);
         $display("vec %0d: rst=%b en=%b col=%0d row=%0d hs=%b vs=%b act=%b fs=%b",
                  i, tbl[i].rst, tbl[i].en, col, row, hs, vs, act, fs);
      end

      // Horizontal timing on row 0 (cols 0..2 were already seen above).
      line_check("line0", A_COLS - 3);

      // Enable gating around the HSync start.
      run_to(654, 1, 2 * T_COLS);
      hand_step("gate_a", 1'b1, 655, 1, 1'b1, 1'b0);
      hand_step("gate_b", 1'b1, 656, 1, (DLY == 0) ? 1'b0 : 1'b1, 1'b0);
      hand_step("gate_hold1", 1'b0, 656, 1, (DLY == 0) ? 1'b0 : 1'b1, 1'b0);
      hand_step("gate_hold2", 1'b0, 656, 1, (DLY == 0) ? 1'b0 : 1'b1, 1'b0);
      hand_step("gate_c", 1'b1, 657, 1, (DLY == 0) ? 1'b0 : 1'b1, 1'b0);

      // Finish this frame, then measure one complete frame.
      found = 0;
      for (int k = 0; k < T_COLS * T_ROWS + 10; k++) begin
         sb_step(1'b0, 1'b1, 1'b0, '0);
         if (fs) begin found = 1; break; end
      end
      check_int("frame_first_wrap_seen", int'(found), 1);

      period = 0; vs_low = 0; late_act = 0; pc = -1; pr = -1; found = 0;
      act_n = int'(act);
      for (int k = 0; k < T_COLS * T_ROWS + 10; k++) begin
         pc = int'(col);
         pr = int'(row);
         sb_step(1'b0, 1'b1, 1'b0, '0);
         period++;
         if (fs) begin found = 1; break; end
         if (!vs) vs_low++;
         if (act) act_n++;
         if (act && int'(row) >= A_ROWS) late_act++;
      end
      check_int("frame_wrap_seen", int'(found), 1);
      check_int("frame_period", period, T_COLS * T_ROWS);
      check_int("frame_vs_low_cycles", vs_low, VSW * T_COLS);
      check_int("frame_active_cycles", act_n, A_COLS * A_ROWS);
      check_int("frame_active_in_blank_rows", late_act, 0);
      check_int("frame_prev_col", pc, T_COLS - 1);
      check_int("frame_prev_row", pr, T_ROWS - 1);
      check_int("frame_wrap_col", int'(col), 0);
      check_int("frame_wrap_row", int'(row), 0);
      $display("frame: period=%0d vs_low=%0d active=%0d", period, vs_low, act_n);

      // Holding at (0,0) must not repeat the frame-start strobe.
      hand_step("hold00_a", 1'b0, 0, 0, 1'b1, 1'b0);
      hand_step("hold00_b", 1'b0, 0, 0, 1'b1, 1'b0);
      hand_step("hold00_c", 1'b1, 1, 0, 1'b1, 1'b0);

      // Reset mid-frame, then a full line must match the first-line timing.
      run_to(300, 3, T_COLS * T_ROWS);
      sb_step(1'b1, 1'b1, 1'b0, '0);
      check_int("midrst_col", int'(col), 0);
      check_int("midrst_row", int'(row), 0);
      check_int("midrst_hs", int'(hs), 1);
      check_int("midrst_vs", int'(vs), 1);
      check_int("midrst_act", int'(act), 0);
      check_int("midrst_fs", int'(fs), 0);
      $display("step midrst: col=%0d row=%0d hs=%b vs=%b act=%b fs=%b", col, row, hs, vs, act, fs);
      hand_step("midrst_release", 1'b1, 0, 0, 1'b1, 1'b1);
      line_check("line_after_rst", A_COLS);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Generates the VGA raster timing (HSync, VSync, column/row counts, active-video flag, frame-start strobe) that the game and video pipeline consume. It is the source end of the HSync/VSync interface that downstream sync-to-count and drawing logic decodes. It sits at the top of the video path, driven by the pixel clock, with a pixel-enable input for clock-divided operation.

Parameters:
TOTAL_COLS, 800, pixels per line including blanking
TOTAL_ROWS, 525, lines per frame including blanking
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
H_FRONT_PORCH, 16, pixels between end of active video and HSync start
H_SYNC_WIDTH, 96, HSync pulse width in pixels
V_FRONT_PORCH, 10, lines between end of active video and VSync start
V_SYNC_WIDTH, 2, VSync pulse width in lines
SYNC_DELAY, 2, cycles of sync delay (used only with VGA_SYNC_ALIGN_EN)

Ports:
i_Clk  in  1  pixel clock
i_Reset  in  1  synchronous, active-high reset
i_Enable  in  1  pixel enable; counters advance only when 1
o_HSync  out  1  horizontal sync, active-low
o_VSync  out  1  vertical sync, active-low
o_Col_Count  out  10  current column, 0..TOTAL_COLS-1
o_Row_Count  out  10  current row, 0..TOTAL_ROWS-1
o_Active  out  1  1 when col<ACTIVE_COLS and row<ACTIVE_ROWS
o_Frame_Start  out  1  single-cycle strobe on first cycle at (0,0)

Behaviour:
- Reset, while i_Reset=1: col=0, row=0, o_HSync=1, o_VSync=1, o_Active=0, o_Frame_Start=0.
- Counting when i_Enable=1: col increments each cycle.
  - At col=TOTAL_COLS-1, col wraps to 0 and row increments.
  - At col=TOTAL_COLS-1 and row=TOTAL_ROWS-1, both wrap to 0.
- Counting when i_Enable=0: counters and all level outputs hold; o_Frame_Start=0.
- Registered decodes: all outputs are registers.
  - Each decode is computed from the next-state counter values, so flags and counts in a given cycle describe the same pixel.
  - No cycle skew between outputs.
- o_HSync=0 iff col in [ACTIVE_COLS+H_FRONT_PORCH, ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH-1]; default 656..751.
- o_VSync=0 iff row in [ACTIVE_ROWS+V_FRONT_PORCH, ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH-1]; default 490..491.
  - VSync changes together with row, i.e. on the col 799->0 transition.
- o_Active=1 iff col<ACTIVE_COLS and row<ACTIVE_ROWS.
- o_Frame_Start asserts for exactly one cycle on the first cycle counters reach (0,0):
  - after a 524/799 wrap with enable high;
  - on the first cycle after reset deasserts.
  - It stays 0 while the counters hold at (0,0) with i_Enable=0.
- Reset mid-frame: next cycle returns to the reset values above; counting resumes from (0,0) after release.
- Width: counters are 10 bits. Parameters must satisfy TOTAL_COLS<=1024 and TOTAL_ROWS<=1024; checked by an elaboration-time assertion.

Optional Feature:
VGA_SYNC_ALIGN_EN
- Defined: o_HSync and o_VSync pass through a SYNC_DELAY-stage delay line.
  - The delay line shifts only when i_Enable=1.
  - Reset fills every stage with 1.
  - This matches the downstream count/draw pipeline latency.
  - Counts, o_Active and o_Frame_Start are not delayed.
- Undefined: syncs are aligned with the counters as described above; SYNC_DELAY is ignored.

Decomposition:
- Shared package vga_timing_pkg:
  - 640x480@60 default constants (totals, actives, porches, sync widths);
  - SYNC_ACTIVE_LEVEL=0;
  - 10-bit count typedef, reused by downstream sync-to-count logic.
- One natural sub-module, vga_sync_delay: a parameterised enable-gated delay line with reset-to-1, instantiated only under VGA_SYNC_ALIGN_EN.

Test Plan:
- Reset: i_Reset=1 for 5 cycles with i_Enable=1 -> col=0, row=0, HSync=1, VSync=1, Active=0, Frame_Start=0. First cycle after release -> Frame_Start=1.
- Horizontal timing: run one line with enable=1.
  - Active=1 for cols 0..639 on row 0.
  - HSync=0 exactly for cols 656..751, i.e. 96 cycles.
  - col 799 -> 0 with row 0 -> 1.
- Vertical/frame wrap: run a full frame.
  - VSync=0 exactly for rows 490..491, i.e. 1600 cycles.
  - Active=0 for rows 480..524.
  - (524,799) -> (0,0) with Frame_Start=1 for 1 cycle; period 420000 cycles.
- Enable gating: toggle i_Enable 1,0,0,1 at col 655.
  - Counts hold at 656 for the two low cycles.
  - HSync low begins at col 656 and stays constant during the hold.
  - Drive enable=0 at (0,0) -> Frame_Start not re-asserted.
- Reset mid-frame: assert i_Reset at (300,123) -> next cycle (0,0) with syncs high. After release, a full line reproduces the horizontal-timing test.
- VGA_SYNC_ALIGN_EN, SYNC_DELAY=2 -> HSync=0 observed at col counts 658..753 and VSync low lines shifted by 2 enabled cycles; counts and Active are unchanged versus the non-macro build.
